// File: rtl/ifu_pkg.sv
// Shared widths, fetch entry type and NOP encoding for the instruction fetch unit.
package ifu_pkg;
   localparam int IMEM_ADDR_WIDTH_DEF = 9;
   localparam int INST_WIDTH_DEF      = 32;

   localparam logic [INST_WIDTH_DEF-1:0] NOP_INST = '0;

   typedef struct packed {
      logic [INST_WIDTH_DEF-1:0]      inst;
      logic [IMEM_ADDR_WIDTH_DEF-1:0] pc;
   } fetch_entry_t;
endpackage

// File: rtl/ifu_fifo.sv
// Prefetch queue: power-of-two depth synchronous FIFO with flush; flush beats push.
module ifu_fifo
   import ifu_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int DATA_WIDTH = $bits(fetch_entry_t),
   localparam int PTR_W     = $clog2(DEPTH),
   localparam int CNT_W     = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [CNT_W-1:0]      count,
   output logic                  full,
   output logic                  empty
);
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      head;
   logic [PTR_W-1:0]      tail;
   logic                  do_push;
   logic                  do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[head];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_push) tail <= tail + PTR_W'(1);
         if (do_pop)  head <= head + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; reads are masked by empty at the top level.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[tail] <= wdata;
   end
endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction fetch front end: credit-based prefetch into a queue, redirect flush, host write port.
// Optional fetch_count output with IFU_FETCH_CNT_EN.
module if_prefetch_unit
   import ifu_pkg::*;
#(
   parameter int IMEM_ADDR_WIDTH = IMEM_ADDR_WIDTH_DEF,
   parameter int INST_WIDTH      = INST_WIDTH_DEF,
   parameter int FIFO_DEPTH      = 4,
   parameter int RESET_PC        = 0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       redirect_valid,
   input  logic [IMEM_ADDR_WIDTH-1:0] redirect_pc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [INST_WIDTH-1:0]      out_inst,
   output logic [IMEM_ADDR_WIDTH-1:0] out_pc,
   input  logic                       prog_we,
   input  logic [IMEM_ADDR_WIDTH-1:0] prog_addr,
   input  logic [INST_WIDTH-1:0]      prog_wdata,
   output logic                       imem_en,
   output logic                       imem_we,
   output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
   output logic [INST_WIDTH-1:0]      imem_wdata,
   input  logic [INST_WIDTH-1:0]      imem_rdata
`ifdef IFU_FETCH_CNT_EN
   ,
   output logic [31:0]                fetch_count
`endif
);
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int DATA_W = INST_WIDTH + IMEM_ADDR_WIDTH;

   logic [IMEM_ADDR_WIDTH-1:0] fetch_pc;
   logic [IMEM_ADDR_WIDTH-1:0] fetch_addr;
   logic                       resp_pending;
   logic [IMEM_ADDR_WIDTH-1:0] resp_pc;
   logic [CNT_W-1:0]           fifo_count;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic [DATA_W-1:0]          fifo_rdata;
   logic [CNT_W:0]             in_flight;
   logic                       prog_active;
   logic                       issue;
   logic                       push;
   logic                       pop;

   // Credit counts queued entries plus the read in flight; a same-cycle pop is not credited.
   assign in_flight   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, resp_pending};
   assign prog_active = prog_we && !reset;
   assign issue       = !reset && !prog_we && (in_flight < (CNT_W+1)'(FIFO_DEPTH));
   assign fetch_addr  = redirect_valid ? redirect_pc : fetch_pc;

   assign imem_en    = prog_active || issue;
   assign imem_we    = prog_active;
   assign imem_addr  = prog_active ? prog_addr : fetch_addr;
   assign imem_wdata = prog_active ? prog_wdata : '0;

   // ID handshake: an entry transfers on any cycle where out_valid and out_ready are both high;
   // out_valid never depends on out_ready, and the head holds steady until it transfers.
   assign out_valid = !fifo_empty;
   assign out_inst  = fifo_empty ? INST_WIDTH'(NOP_INST) : fifo_rdata[DATA_W-1 -: INST_WIDTH];
   assign out_pc    = fifo_empty ? '0 : fifo_rdata[IMEM_ADDR_WIDTH-1:0];
   assign pop       = out_valid && out_ready;
   assign push      = resp_pending && !redirect_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc     <= IMEM_ADDR_WIDTH'(RESET_PC);
         resp_pending <= 1'b0;
         resp_pc      <= '0;
      end else if (issue) begin
         fetch_pc     <= fetch_addr + IMEM_ADDR_WIDTH'(1);
         resp_pending <= 1'b1;
         resp_pc      <= fetch_addr;
      end else begin
         if (redirect_valid) fetch_pc <= redirect_pc;
         resp_pending <= 1'b0;
      end
   end

   ifu_fifo #(
      .DEPTH      (FIFO_DEPTH),
      .DATA_WIDTH (DATA_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .wdata ({imem_rdata, resp_pc}),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   push_when_full_a: assert property (@(posedge clk) disable iff (reset) !(push && fifo_full));

`ifdef IFU_FETCH_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)    fetch_count <= '0;
      else if (pop) fetch_count <= fetch_count + 32'd1;
   end
`endif
endmodule
